// File: rtl/atcaxi2tluh500_arb_mux_pkg.sv
// Shared definitions for the AXI-to-TL-UH request arbiter.
// Provides the clog2 helper used to validate the out_idx width at elaboration.
package atcaxi2tluh500_arb_mux_pkg;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/atcaxi2tluh500_mux_onehot.sv
// One-hot AND-OR multiplexer.
//   sel_i  : one-hot (or zero) select, N bits
//   data_i : N packed inputs, input i at [i*W +: W]
//   data_o : OR of the selected inputs; zero when sel_i is zero
module atcaxi2tluh500_mux_onehot #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8
) (
  input  logic [N-1:0]   sel_i,
  input  logic [N*W-1:0] data_i,
  output logic [W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      data_o = data_o | ({W{sel_i[i]}} & data_i[i*W +: W]);
    end
  end

endmodule

// File: rtl/atcaxi2tluh500_arb_mux.sv
// Burst-aware N-channel round-robin arbiter merging AXI-side request streams
// onto the single TL-UH A-channel path.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   in_valid/last/data   : per-channel request (payload i at [i*W +: W])
//   in_ready             : per-channel accept (only ever on the granted channel)
//   out_valid/last/data  : merged beat
//   out_grant, out_idx   : one-hot and binary source of the current beat
//   out_ready            : downstream accept
// Build option: define ATCAXI2TLUH500_ARB_OUT_REG_EN to add a 1-entry output
// register (1-cycle latency, full throughput). Default build is combinational.
module atcaxi2tluh500_arb_mux
  import atcaxi2tluh500_arb_mux_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned W   = 8,
  parameter int unsigned IDW = 1
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic           out_last,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_grant,
  output logic [IDW-1:0] out_idx,
  input  logic           out_ready
);

  if (IDW < clog2(N)) begin : g_bad_idw
    $error("IDW too narrow for N");
  end

  logic [N-1:0]   rr_ptr_q, rr_ptr_d;
  logic           lock_q, lock_d;
  logic           hold_q, hold_d;
  logic [N-1:0]   grant_q, grant_d;

  logic [2*N-1:0] dbl_req, ptr_ext, masked, first;
  logic [N-1:0]   rr_grant, cur_grant;
  logic [IDW-1:0] cur_idx;
  logic [W-1:0]   mux_data;
  logic           mux_last;
  logic           arb_valid, arb_ready;

  // Find-first at or above rr_ptr with wrap: mask the low copy below the
  // pointer, keep the high copy whole, then fold the two halves together.
  always_comb begin
    dbl_req  = {in_valid, in_valid};
    ptr_ext  = {{N{1'b0}}, rr_ptr_q};
    masked   = dbl_req & ~(ptr_ext - (2*N)'(1));
    first    = masked & (~masked + (2*N)'(1));
    rr_grant = first[N-1:0] | first[2*N-1:N];
  end

  // Frozen grant while a burst is in flight or a beat is stalled. Reset
  // gates the grant so nothing is offered while aresetn is low.
  assign cur_grant = !aresetn         ? '0 :
                     (lock_q | hold_q) ? grant_q : rr_grant;

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cur_grant[i]) cur_idx = cur_idx | IDW'(i);
    end
  end

  atcaxi2tluh500_mux_onehot #(
    .N(N),
    .W(W)
  ) u_mux_data (
    .sel_i  (cur_grant),
    .data_i (in_data),
    .data_o (mux_data)
  );

  atcaxi2tluh500_mux_onehot #(
    .N(N),
    .W(1)
  ) u_mux_last (
    .sel_i  (cur_grant),
    .data_i (in_last),
    .data_o (mux_last)
  );

  assign arb_valid = |(cur_grant & in_valid);
  assign in_ready  = cur_grant & {N{arb_ready}};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    if (arb_valid && arb_ready) begin
      hold_d = 1'b0;
      if (mux_last) begin
        lock_d   = 1'b0;
        rr_ptr_d = {cur_grant[N-2:0], cur_grant[N-1]};
      end else begin
        lock_d  = 1'b1;
        grant_d = cur_grant;
      end
    end else if (arb_valid) begin
      hold_d  = 1'b1;
      grant_d = cur_grant;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q <= {{(N-1){1'b0}}, 1'b1};
      lock_q   <= 1'b0;
      hold_q   <= 1'b0;
      grant_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
    end
  end

`ifdef ATCAXI2TLUH500_ARB_OUT_REG_EN
  logic           full_q;
  logic           last_q;
  logic [W-1:0]   data_q;
  logic [N-1:0]   ogrant_q;
  logic [IDW-1:0] idx_q;

  // Empty slot or draining slot can take a new beat every cycle.
  assign arb_ready = !full_q | out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_q   <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      ogrant_q <= '0;
      idx_q    <= '0;
    end else if (arb_valid && arb_ready) begin
      full_q   <= 1'b1;
      last_q   <= mux_last;
      data_q   <= mux_data;
      ogrant_q <= cur_grant;
      idx_q    <= cur_idx;
    end else if (out_ready) begin
      full_q <= 1'b0;
    end
  end

  assign out_valid = full_q;
  assign out_last  = last_q;
  assign out_data  = data_q;
  assign out_grant = ogrant_q;
  assign out_idx   = idx_q;
`else
  assign arb_ready = out_ready;
  assign out_valid = arb_valid;
  assign out_last  = mux_last;
  assign out_data  = mux_data;
  assign out_grant = cur_grant;
  assign out_idx   = cur_idx;
`endif

endmodule
